// File: rtl/fp_vec_argmax.sv
// Streaming argmax/argmin over a LEN-element vector of sign-magnitude floats,
// returning the extreme element, its index and a NaN-seen flag.
module fp_vec_argmax #(
    parameter int unsigned EXP_W    = 5,
    parameter int unsigned MAN_W    = 10,
    parameter int unsigned LEN      = 16,
    parameter int unsigned IDX_W    = $clog2(LEN),
    parameter int unsigned NAN_PROP = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   in_data,
    input  logic                   in_min,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_data,
    output logic [IDX_W-1:0]       out_index,
    output logic                   out_nan,
    output logic                   busy
);

    localparam int unsigned W = 1 + EXP_W + MAN_W;

    typedef enum logic {ACC = 1'b0, HOLD = 1'b1} state_t;

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  cnt, cnt_nxt;
    logic              min_mode;
    logic              accept, first, last, mode;
    logic              in_is_nan, best_is_nan, cand_better, take;

    // Maps sign-magnitude onto an unsigned key whose order matches the float order (-0 < +0).
    function automatic logic [W-1:0] order_key(input logic [W-1:0] v);
        order_key = v[W-1] ? {1'b0, ~v[W-2:0]} : {1'b1, v[W-2:0]};
    endfunction

    function automatic logic is_nan(input logic [W-1:0] v);
        is_nan = (&v[W-2:MAN_W]) && (|v[MAN_W-1:0]);
    endfunction

    // Replacement decision for the running best
    always_comb begin
        accept      = in_valid & in_ready;
        first       = (cnt == '0);
        last        = (cnt == IDX_W'(LEN - 1));
        mode        = first ? in_min : min_mode;
        in_is_nan   = is_nan(in_data);
        best_is_nan = is_nan(out_data);
        cand_better = mode ? (order_key(in_data) < order_key(out_data))
                           : (order_key(in_data) > order_key(out_data));
        take        = 1'b0;
        if (NAN_PROP != 0) begin
            take = !best_is_nan && (in_is_nan || cand_better);
        end else begin
            take = !in_is_nan && (best_is_nan || cand_better);
        end
    end

    // Next state and element counter
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ACC: begin
                if (accept) begin
                    cnt_nxt = last ? '0 : IDX_W'(cnt + 1'b1);
                    if (last) begin
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_valid && out_ready) begin
                    state_nxt = ACC;
                end
            end
            default: state_nxt = ACC;
        endcase
    end

    // State, counter and handshake outputs, registered from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ACC;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            in_ready  <= (state_nxt == ACC);
            out_valid <= (state_nxt == HOLD);
            busy      <= (state_nxt == ACC) && (cnt_nxt != '0);
        end
    end

    // Running best doubles as the result register; it is frozen while in HOLD
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_index <= '0;
            out_nan   <= 1'b0;
            min_mode  <= 1'b0;
        end else if (accept) begin
            if (first) begin
                out_data  <= in_data;
                out_index <= '0;
                out_nan   <= in_is_nan;
                min_mode  <= in_min;
            end else begin
                if (take) begin
                    out_data  <= in_data;
                    out_index <= cnt;
                end
                out_nan <= out_nan | in_is_nan;
            end
        end
    end

endmodule

// File: tb/tb_fp_vec_argmax.sv
// Self-checking bench for fp_vec_argmax: two LEN=4 instances (NaN propagate / ignore)
// fed the same stream, checked against a whole-vector reference model.
module tb_fp_vec_argmax;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_min, out_ready;
    logic [15:0] in_data;

    logic        rdy1, ov1, on1, busy1;
    logic [15:0] od1;
    logic [1:0]  oi1;
    logic        rdy0, ov0, on0, busy0;
    logic [15:0] od0;
    logic [1:0]  oi0;

    int tests = 0;
    int fails = 0;

    logic [15:0] vec [4];
    logic        vmin;

    always #5 clk = ~clk;

    fp_vec_argmax #(.EXP_W(5), .MAN_W(10), .LEN(4), .NAN_PROP(1)) dut_p (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
        .in_min(in_min), .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
        .out_index(oi1), .out_nan(on1), .busy(busy1));

    fp_vec_argmax #(.EXP_W(5), .MAN_W(10), .LEN(4), .NAN_PROP(0)) dut_i (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
        .in_min(in_min), .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
        .out_index(oi0), .out_nan(on0), .busy(busy0));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit f_nan(input logic [15:0] v);
        return (v[14:10] == 5'h1F) && (v[9:0] != 10'h0);
    endfunction

    // Signed rank: positives by magnitude, negatives below them, -0 just under +0
    function automatic int rank(input logic [15:0] v);
        return v[15] ? -int'({17'h0, v[14:0]}) - 1 : int'({17'h0, v[14:0]});
    endfunction

    task automatic model(input bit prop, output logic [15:0] d, output int idx, output bit nan);
        int first_nan = -1;
        idx = -1;
        nan = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (f_nan(vec[i])) begin
                nan = 1'b1;
                if (first_nan < 0) first_nan = i;
            end
        end
        if (prop && nan) begin
            idx = first_nan;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (!f_nan(vec[i])) begin
                    if (idx < 0) idx = i;
                    else if (vmin ? (rank(vec[i]) < rank(vec[idx])) : (rank(vec[i]) > rank(vec[idx])))
                        idx = i;
                end
            end
            if (idx < 0) idx = 0;
        end
        d = vec[idx];
    endtask

    function automatic logic [15:0] rnd_elem(input logic [15:0] prev);
        logic [15:0] r;
        r = 16'($urandom);
        case ($urandom_range(0, 7))
            0: r = {r[15], 5'h1F, 10'($urandom_range(1, 1023))};
            1: r = {r[15], 5'h1F, 10'h0};
            2: r = {r[15], 15'h0};
            3: r = prev;
            default: if (r[14:10] == 5'h1F) r[14:10] = 5'h1E;
        endcase
        return r;
    endfunction

    // Feeds vec[] with optional idle gaps; in_min is only meaningful on element 0
    task automatic send_vec(input bit gaps);
        bit acc;
        int n;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (gaps && $urandom_range(0, 1) == 1 && n < 6) begin
                in_valid = 1'b0;
                in_data  = 16'($urandom);
                in_min   = 1'($urandom);
                @(posedge clk); #1;
                n++;
            end
            in_valid = 1'b1;
            in_data  = vec[i];
            in_min   = (i == 0) ? vmin : ~vmin;
            n = 0;
            do begin
                acc = rdy1;
                @(posedge clk); #1;
                n++;
            end while (!acc && n < 50);
            if (!acc) begin
                fails++;
                $error("FAIL accept_timeout: element %0d not accepted within 50 cycles", i);
            end
        end
        in_valid = 1'b0;
        in_data  = 16'($urandom);
    endtask

    task automatic check_both(input string tag);
        logic [15:0] d;
        int idx;
        bit nan;
        model(1'b1, d, idx, nan);
        chk({tag, "_p_valid"}, 32'(ov1), 32'(1));
        chk({tag, "_p_data"},  32'(od1), 32'(d));
        chk({tag, "_p_index"}, 32'(oi1), 32'(idx));
        chk({tag, "_p_nan"},   32'(on1), 32'(nan));
        model(1'b0, d, idx, nan);
        chk({tag, "_i_valid"}, 32'(ov0), 32'(1));
        chk({tag, "_i_data"},  32'(od0), 32'(d));
        chk({tag, "_i_index"}, 32'(oi0), 32'(idx));
        chk({tag, "_i_nan"},   32'(on0), 32'(nan));
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_rel_valid"}, 32'(ov1), 32'(0));
        chk({tag, "_rel_ready"}, 32'(rdy1), 32'(1));
    endtask

    initial begin
        logic [15:0] prev;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_min    = 1'b0;
        out_ready = 1'b0;
        in_data   = 16'h0;
        #1;
        chk("rst_valid", 32'(ov1), 32'(0));
        chk("rst_ready", 32'(rdy1), 32'(1));
        chk("rst_busy",  32'(busy1), 32'(0));
        chk("rst_data",  32'(od1), 32'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Max mode
        vec = '{16'h3C00, 16'h4000, 16'hC000, 16'h3C00}; vmin = 1'b0;
        send_vec(1'b0);
        chk("max_data",  32'(od1), 32'h4000);
        chk("max_index", 32'(oi1), 32'(1));
        chk("max_nan",   32'(on1), 32'(0));
        check_both("max");
        release_out("max");

        // Min mode
        vmin = 1'b1;
        send_vec(1'b0);
        chk("min_data",  32'(od1), 32'hC000);
        chk("min_index", 32'(oi1), 32'(2));
        release_out("min");

        // Signed zeros and tie keeps earliest
        vec = '{16'h8000, 16'h0000, 16'h0000, 16'h8000}; vmin = 1'b0;
        send_vec(1'b0);
        chk("zero_data",  32'(od1), 32'h0000);
        chk("zero_index", 32'(oi1), 32'(1));
        release_out("zero");

        // NaN handling, then hold with back-pressure
        vec = '{16'h3C00, 16'h7E00, 16'h7C00, 16'h7E01};
        send_vec(1'b0);
        chk("nanp_data",  32'(od1), 32'h7E00);
        chk("nanp_index", 32'(oi1), 32'(1));
        chk("nanp_nan",   32'(on1), 32'(1));
        chk("nani_data",  32'(od0), 32'h7C00);
        chk("nani_index", 32'(oi0), 32'(2));
        chk("nani_nan",   32'(on0), 32'(1));
        in_valid = 1'b1;
        in_data  = 16'h5555;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(ov1), 32'(1));
            chk("hold_ready", 32'(rdy1), 32'(0));
            chk("hold_data",  32'(od1), 32'h7E00);
            chk("hold_index", 32'(oi1), 32'(1));
        end
        in_valid = 1'b0;
        release_out("hold");

        // Reset mid-vector after two accepts
        in_valid = 1'b1;
        in_min   = 1'b0;
        in_data  = 16'h7BFF;
        @(posedge clk); #1;
        in_data  = 16'h7C00;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("mid_busy", 32'(busy1), 32'(1));
        rst = 1'b1;
        #1;
        chk("mrst_busy",  32'(busy1), 32'(0));
        chk("mrst_ready", 32'(rdy1), 32'(1));
        chk("mrst_valid", 32'(ov1), 32'(0));
        chk("mrst_data",  32'(od1), 32'(0));
        chk("mrst_index", 32'(oi1), 32'(0));
        chk("mrst_nan",   32'(on1), 32'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        vec = '{16'hBC00, 16'hC000, 16'h3800, 16'hBC00}; vmin = 1'b0;
        send_vec(1'b0);
        chk("fresh_data",  32'(od1), 32'h3800);
        chk("fresh_index", 32'(oi1), 32'(2));
        check_both("fresh");
        release_out("fresh");

        // Randomised vectors with input gaps and output back-pressure
        prev = 16'h0;
        for (int v = 0; v < 100; v++) begin
            for (int i = 0; i < 4; i++) begin
                vec[i] = rnd_elem(prev);
                prev   = vec[i];
            end
            vmin = 1'($urandom);
            send_vec(1'b1);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            check_both("rnd");
            release_out("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
